store_buffer: RTL and testbench

Four-entry store queue that sits directly upstream of the data memory in the MEM stage of the 16-bit pipelined CPU. Stores retire into the buffer in one cycle. The buffer drains them to the memory's single shared address port on cycles when no load needs that port. Loads always get the port, and load data is forwarded from buffered stores (youngest match wins), time-aligned with the memory's one-cycle synchronous read latency.

---
 rtl/store_buffer.sv | 139 +++++++++++++
 tb/tb_store_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer
//
// Store queue in front of the single-ported data memory of the MEM stage.
// A store is accepted in the cycle it is presented. It drains to memory on
// any cycle without a load. Loads always own the memory port. Load data is
// forwarded from buffered stores (youngest match wins) and comes back one
// cycle later, in step with the memory's synchronous read.
//
// Ports
//   clk_i / rst_ni       clock, asynchronous active-low reset
//   st_valid_i/addr/data store request from EX/MEM
//   ld_valid_i/addr      load request from EX/MEM
//   stall_o              store not accepted this cycle; pipeline holds
//   mem_addr_o/wd/we     data memory port (combinational)
//   mem_rd_i             memory read data, valid the cycle after the address
//   ld_data_o/valid_o    load result for MEM/WB, one cycle after the load
//   count_o / empty_o    occupancy of the buffer
module store_buffer #(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       st_valid_i,
    input  logic [15:0]                st_addr_i,
    input  logic [15:0]                st_data_i,
    input  logic                       ld_valid_i,
    input  logic [15:0]                ld_addr_i,
    output logic                       stall_o,
    output logic [15:0]                mem_addr_o,
    output logic [15:0]                mem_wd_o,
    output logic                       mem_we_o,
    input  logic [15:0]                mem_rd_i,
    output logic [15:0]                ld_data_o,
    output logic                       ld_data_valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [15:0]   addr_q [DEPTH];
    logic [15:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          ld_valid_q;
    logic          fwd_hit_q, fwd_hit_d;
    logic [15:0]   fwd_data_q, fwd_data_d;

    logic          pop;
    logic          accept;
    logic          push;
    logic          in_range;
    logic [PW-1:0] idx;

    // Loads own the port, so the head can only drain on load-free cycles.
    assign pop      = !ld_valid_i && (count_q != '0);
    assign accept   = st_valid_i && !ld_valid_i && (count_q < FULL);
    assign in_range = {16'h0, st_addr_i} < 32'(MEM_WORDS);
    // Out-of-range stores are acknowledged but dropped on the floor.
    assign push     = accept && in_range;

    assign stall_o  = st_valid_i && (ld_valid_i || (count_q == FULL));

    always_comb begin
        mem_addr_o = '0;
        mem_wd_o   = '0;
        mem_we_o   = 1'b0;
        if (ld_valid_i) begin
            mem_addr_o = ld_addr_i;
        end else if (count_q != '0) begin
            mem_addr_o = addr_q[head_q];
            mem_wd_o   = data_q[head_q];
            mem_we_o   = 1'b1;
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Walk occupied entries oldest to youngest; later matches overwrite
    // earlier ones so the youngest store wins.
    always_comb begin
        fwd_hit_d  = 1'b0;
        fwd_data_d = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((i < int'(count_q)) && (addr_q[idx] == ld_addr_i)) begin
                fwd_hit_d  = 1'b1;
                fwd_data_d = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ld_valid_q <= 1'b0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ld_valid_q <= ld_valid_i;
            fwd_hit_q  <= ld_valid_i && fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail_q] <= st_addr_i;
            data_q[tail_q] <= st_data_i;
        end
    end

    assign ld_data_valid_o = ld_valid_q;
    assign ld_data_o       = !ld_valid_q ? 16'h0 : (fwd_hit_q ? fwd_data_q : mem_rd_i);
    assign count_o         = count_q;
    assign empty_o         = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 256;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        st_valid_i;
    logic [15:0] st_addr_i, st_data_i;
    logic        ld_valid_i;
    logic [15:0] ld_addr_i;
    logic        stall_o;
    logic [15:0] mem_addr_o, mem_wd_o;
    logic        mem_we_o;
    logic [15:0] mem_rd_i;
    logic [15:0] ld_data_o;
    logic        ld_data_valid_o;
    logic [2:0]  count_o;
    logic        empty_o;

    always #5 clk_i = ~clk_i;

    store_buffer #(.DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .st_valid_i(st_valid_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
        .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i),
        .stall_o(stall_o), .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_we_o(mem_we_o),
        .mem_rd_i(mem_rd_i), .ld_data_o(ld_data_o), .ld_data_valid_o(ld_data_valid_o),
        .count_o(count_o), .empty_o(empty_o)
    );

    function automatic logic [15:0] init_word(int i);
        return (i == 3) ? 16'h00AA : 16'(i * 37 + 16'h1000);
    endfunction

    // Synchronous-read data memory seen by the DUT.
    logic [15:0] sram [MEM_WORDS];
    bit          sram_ready;
    always @(posedge clk_i) begin
        if (!sram_ready) begin
            for (int i = 0; i < MEM_WORDS; i++) sram[i] <= init_word(i);
            sram_ready <= 1'b1;
        end else begin
            if (mem_we_o && mem_addr_o < MEM_WORDS) sram[mem_addr_o[7:0]] <= mem_wd_o;
            mem_rd_i <= (mem_addr_o < MEM_WORDS) ? sram[mem_addr_o[7:0]] : 16'h0;
        end
    end

    // Reference model: an ordered list of pending stores plus a memory image.
    typedef struct { logic [15:0] a; logic [15:0] d; } ent_t;
    ent_t        q[$];
    logic [15:0] ref_mem [MEM_WORDS];
    logic        exp_stall, exp_we, exp_ldv;
    logic [15:0] exp_addr, exp_wd, exp_ldd;
    int          n_pass = 0;
    int          n_total = 0;

    function automatic logic [15:0] ref_read(logic [15:0] a);
        return (a < MEM_WORDS) ? ref_mem[int'(a)] : 16'h0;
    endfunction

    task automatic model_comb();
        exp_stall = st_valid_i && (ld_valid_i || q.size() == DEPTH);
        exp_addr = 16'h0; exp_wd = 16'h0; exp_we = 1'b0;
        if (ld_valid_i) exp_addr = ld_addr_i;
        else if (q.size() != 0) begin exp_addr = q[0].a; exp_wd = q[0].d; exp_we = 1'b1; end
    endtask

    task automatic model_seq();
        int   n;
        ent_t e;
        n = q.size();
        exp_ldv = ld_valid_i;
        exp_ldd = 16'h0;
        if (ld_valid_i) begin
            exp_ldd = ref_read(ld_addr_i);
            foreach (q[i]) if (q[i].a == ld_addr_i) exp_ldd = q[i].d;
        end
        if (!ld_valid_i && n != 0) begin
            e = q.pop_front();
            if (e.a < MEM_WORDS) ref_mem[int'(e.a)] = e.d;
        end
        if (st_valid_i && !ld_valid_i && n < DEPTH && st_addr_i < MEM_WORDS) begin
            e.a = st_addr_i; e.d = st_data_i;
            q.push_back(e);
        end
    endtask

    task automatic set_in(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                          input logic lv, input logic [15:0] la);
        st_valid_i = sv; st_addr_i = sa; st_data_i = sd;
        ld_valid_i = lv; ld_addr_i = la;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_seq();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (count_o !== 3'd0) $display("FAIL reset_count: got %0d want 0", count_o); else n_pass++;
        n_total++; if (empty_o !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty_o); else n_pass++;
        n_total++; if (mem_we_o !== 1'b0) $display("FAIL reset_we: got %b want 0", mem_we_o); else n_pass++;
        n_total++; if (mem_addr_o !== 16'h0 || mem_wd_o !== 16'h0) $display("FAIL reset_port: got %h/%h want 0/0", mem_addr_o, mem_wd_o); else n_pass++;
        n_total++; if (ld_data_valid_o !== 1'b0 || ld_data_o !== 16'h0) $display("FAIL reset_ld: got %b/%h want 0/0", ld_data_valid_o, ld_data_o); else n_pass++;
    endtask

    task automatic test_drain();
        set_in(1'b1, 16'd5, 16'hBEEF, 1'b0, 16'h0); #1;
        n_total++; if (stall_o !== 1'b0) $display("FAIL drain_stall: got %b want 0", stall_o); else n_pass++;
        tick();
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 16'h0); #1;
        n_total++; if (count_o !== 3'd1) $display("FAIL drain_count1: got %0d want 1", count_o); else n_pass++;
        n_total++; if (mem_we_o !== 1'b1 || mem_addr_o !== 16'd5 || mem_wd_o !== 16'hBEEF)
            $display("FAIL drain_write: got we=%b a=%h d=%h want 1/0005/beef", mem_we_o, mem_addr_o, mem_wd_o); else n_pass++;
        tick();
        n_total++; if (count_o !== 3'd0 || empty_o !== 1'b1) $display("FAIL drain_empty: got %0d/%b want 0/1", count_o, empty_o); else n_pass++;
    endtask

    task automatic test_interleave();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) set_in(1'b1, 16'(20 + k), 16'(16'h3000 + k), 1'b0, 16'h0);
            else            set_in(1'b0, 16'h0, 16'h0, 1'b1, 16'd9);
            #1;
            n_total++; if (stall_o !== exp_stall || mem_we_o !== exp_we || mem_addr_o !== exp_addr)
                $display("FAIL interleave_port[%0d]: got s=%b we=%b a=%h want %b/%b/%h", k, stall_o, mem_we_o, mem_addr_o, exp_stall, exp_we, exp_addr); else n_pass++;
            tick();
            n_total++; if (count_o !== 3'(q.size())) $display("FAIL interleave_count[%0d]: got %0d want %0d", k, count_o, q.size()); else n_pass++;
        end
        set_in(1'b1, 16'd40, 16'h4444, 1'b1, 16'd9); #1;
        n_total++; if (stall_o !== 1'b1 || mem_we_o !== 1'b0) $display("FAIL collide: got s=%b we=%b want 1/0", stall_o, mem_we_o); else n_pass++;
        tick();
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
    endtask

    task automatic test_forward_priority();
        set_in(1'b1, 16'd7, 16'h1111, 1'b0, 16'h0); tick();
        set_in(1'b0, 16'h0, 16'h0, 1'b1, 16'd9); #1;
        n_total++; if (mem_we_o !== 1'b0) $display("FAIL fwd_noweA: got %b want 0", mem_we_o); else n_pass++;
        tick();
        set_in(1'b1, 16'd7, 16'h2222, 1'b0, 16'h0); tick();
        set_in(1'b0, 16'h0, 16'h0, 1'b1, 16'd9); #1;
        n_total++; if (mem_we_o !== 1'b0) $display("FAIL fwd_noweB: got %b want 0", mem_we_o); else n_pass++;
        tick();
        set_in(1'b0, 16'h0, 16'h0, 1'b1, 16'd7); #1;
        n_total++; if (mem_we_o !== 1'b0 || mem_addr_o !== 16'd7) $display("FAIL fwd_port: got we=%b a=%h want 0/0007", mem_we_o, mem_addr_o); else n_pass++;
        tick();
        n_total++; if (ld_data_valid_o !== 1'b1 || ld_data_o !== 16'h2222)
            $display("FAIL fwd_youngest: got v=%b d=%h want 1/2222", ld_data_valid_o, ld_data_o); else n_pass++;
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 16'h0); tick();
        n_total++; if (ld_data_valid_o !== 1'b0 || ld_data_o !== 16'h0) $display("FAIL fwd_after: got v=%b d=%h want 0/0000", ld_data_valid_o, ld_data_o); else n_pass++;
    endtask

    task automatic test_forward_miss();
        set_in(1'b1, 16'd4, 16'h0404, 1'b0, 16'h0); tick();
        set_in(1'b0, 16'h0, 16'h0, 1'b1, 16'd3); tick();
        n_total++; if (ld_data_valid_o !== 1'b1 || ld_data_o !== 16'h00AA)
            $display("FAIL fwd_miss: got v=%b d=%h want 1/00aa", ld_data_valid_o, ld_data_o); else n_pass++;
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 16'h0); tick();
    endtask

    task automatic test_out_of_range();
        set_in(1'b1, 16'd300, 16'hDEAD, 1'b0, 16'h0); #1;
        n_total++; if (stall_o !== 1'b0) $display("FAIL oor_stall: got %b want 0", stall_o); else n_pass++;
        tick();
        n_total++; if (count_o !== 3'd0 || empty_o !== 1'b1) $display("FAIL oor_count: got %0d/%b want 0/1", count_o, empty_o); else n_pass++;
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 16'h0); #1;
        n_total++; if (mem_we_o !== 1'b0) $display("FAIL oor_we: got %b want 0", mem_we_o); else n_pass++;
        tick();
        set_in(1'b0, 16'h0, 16'h0, 1'b1, 16'd300); tick();
        n_total++; if (ld_data_valid_o !== 1'b1 || ld_data_o !== 16'h0) $display("FAIL oor_load: got v=%b d=%h want 1/0000", ld_data_valid_o, ld_data_o); else n_pass++;
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 16'h0); tick();
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 16'd2, 16'h1234, 1'b0, 16'h0); tick();
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        #2 rst_ni = 1'b0;
        #1;
        n_total++; if (count_o !== 3'd0 || empty_o !== 1'b1) $display("FAIL rstmid_count: got %0d/%b want 0/1", count_o, empty_o); else n_pass++;
        n_total++; if (mem_we_o !== 1'b0) $display("FAIL rstmid_we: got %b want 0", mem_we_o); else n_pass++;
        q.delete(); exp_ldv = 1'b0; exp_ldd = 16'h0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 16'h0, 16'h0, 1'b0, 16'h0); #1;
            n_total++; if (mem_we_o !== 1'b0) $display("FAIL rstmid_nowrite[%0d]: got %b want 0", k, mem_we_o); else n_pass++;
            tick();
        end
        set_in(1'b0, 16'h0, 16'h0, 1'b1, 16'd2); tick();
        n_total++; if (ld_data_o !== init_word(2)) $display("FAIL rstmid_lost: got %h want %h", ld_data_o, init_word(2)); else n_pass++;
    endtask

    task automatic test_random();
        logic        sv, lv;
        logic [15:0] sa, la;
        for (int k = 0; k < 300; k++) begin
            sv = 1'($urandom_range(0, 1));
            lv = ($urandom_range(0, 2) == 0);
            sa = ($urandom_range(0, 8) == 8) ? 16'd300 : 16'($urandom_range(0, 7));
            la = ($urandom_range(0, 8) == 8) ? 16'd300 : 16'($urandom_range(0, 7));
            set_in(sv, sa, 16'($urandom), lv, la); #1;
            n_total++; if (stall_o !== exp_stall) $display("FAIL rnd_stall[%0d]: got %b want %b", k, stall_o, exp_stall); else n_pass++;
            n_total++; if (mem_we_o !== exp_we || mem_addr_o !== exp_addr || mem_wd_o !== exp_wd)
                $display("FAIL rnd_port[%0d]: got %b/%h/%h want %b/%h/%h", k, mem_we_o, mem_addr_o, mem_wd_o, exp_we, exp_addr, exp_wd); else n_pass++;
            n_total++; if (count_o !== 3'(q.size()) || empty_o !== (q.size() == 0))
                $display("FAIL rnd_count[%0d]: got %0d/%b want %0d", k, count_o, empty_o, q.size()); else n_pass++;
            n_total++; if (ld_data_valid_o !== exp_ldv || ld_data_o !== exp_ldd)
                $display("FAIL rnd_load[%0d]: got %b/%h want %b/%h", k, ld_data_valid_o, ld_data_o, exp_ldv, exp_ldd); else n_pass++;
            tick();
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        st_valid_i = 1'b0; st_addr_i = 16'h0; st_data_i = 16'h0;
        ld_valid_i = 1'b0; ld_addr_i = 16'h0;
        exp_ldv = 1'b0; exp_ldd = 16'h0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        repeat (2) @(negedge clk_i);
        test_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        test_drain();
        test_interleave();
        test_forward_priority();
        test_forward_miss();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_total);
        $fatal(1);
    end

endmodule
